// File: rtl/parking_display_scan.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : parking_display_scan                                           |
// | Brief   : Multiplexed 7-segment driver for the parking status panel.     |
// |           Left group = free-slot count, right group = first empty slot,  |
// |           both converted by a sequential double-dabble engine.           |
// |           Optional blink on a full lot: PARKING_DISPLAY_BLINK_EN.        |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module parking_display_scan #(
  parameter int CAP_W      = 7,
  parameter int IDX_W      = 7,
  parameter int CAP_DIGITS = 2,
  parameter int IDX_DIGITS = 2,
  parameter int BLINK_HALF = 250
) (
  input  logic                             clk_500Hz,
  input  logic                             reset,
  input  logic                             load,
  input  logic [CAP_W-1:0]                 capacity,
  input  logic [IDX_W-1:0]                 first_empty,
  output logic                             busy,
  output logic [CAP_DIGITS+IDX_DIGITS-1:0] anodes,
  output logic [6:0]                       segments
);

  localparam int NUM    = CAP_DIGITS + IDX_DIGITS;
  localparam int WMAX   = (CAP_W > IDX_W) ? CAP_W : IDX_W;
  localparam int BCD_D  = (WMAX * 3) / 10 + 1;
  localparam int BCD_W  = 4 * BCD_D;
  localparam int GRP_D  = (CAP_DIGITS > IDX_DIGITS) ? CAP_DIGITS : IDX_DIGITS;
  localparam int PAD_D  = (BCD_D > GRP_D) ? BCD_D : GRP_D;
  localparam int PAD_W  = 4 * PAD_D;
  localparam int STEP_W = $clog2(WMAX + 1);
  localparam int K_W    = (NUM > 1) ? $clog2(NUM) : 1;

  localparam logic [3:0] c_blank = 4'hF;
  localparam logic [3:0] c_dash  = 4'hE;

  logic [WMAX-1:0]   r_cap_bin, r_idx_bin;
  logic [BCD_W-1:0]  r_cap_bcd, r_idx_bcd;
  logic [STEP_W-1:0] r_step;
  logic              r_busy;
  logic              r_pend;
  logic [CAP_W-1:0]  r_pend_cap;
  logic [IDX_W-1:0]  r_pend_idx;
  logic [3:0]        r_digit [NUM];
  logic              r_cap_zero;
  logic [K_W-1:0]    r_k;

  logic [BCD_W-1:0]  w_cap_bcd_nx, w_idx_bcd_nx;
  logic [PAD_W-1:0]  w_cap_pad, w_idx_pad;
  logic              w_cap_sat, w_idx_sat, w_cap_zero, w_lead;
  logic [3:0]        w_d;
  logic [3:0]        w_new_digit [NUM];
  logic [CAP_W-1:0]  w_src_cap;
  logic [IDX_W-1:0]  w_src_idx;
  logic              w_final;
  logic              w_blink_on;

  function automatic logic [BCD_W-1:0] dabble(input logic [BCD_W-1:0] bcd, input logic bit_in);
    logic [BCD_W-1:0] adj;
    adj = bcd;
    for (int i = 0; i < BCD_D; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    return {adj[BCD_W-2:0], bit_in};
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      c_dash:  return 7'b0111111;
      default: return 7'b1111111;
    endcase
  endfunction

  assign w_cap_bcd_nx = dabble(r_cap_bcd, r_cap_bin[WMAX-1]);
  assign w_idx_bcd_nx = dabble(r_idx_bcd, r_idx_bin[WMAX-1]);
  assign w_src_cap    = load ? capacity    : r_pend_cap;
  assign w_src_idx    = load ? first_empty : r_pend_idx;
  assign w_final      = r_busy && (r_step == STEP_W'(WMAX - 1));
  assign busy         = r_busy;

  // Format both groups from the result of the final dabble step
  always_comb begin
    w_cap_pad  = PAD_W'(w_cap_bcd_nx);
    w_idx_pad  = PAD_W'(w_idx_bcd_nx);
    w_cap_zero = (w_cap_bcd_nx == '0);
    w_cap_sat  = 1'b0;
    w_idx_sat  = 1'b0;
    w_lead     = 1'b1;
    w_d        = 4'd0;
    for (int i = 0; i < NUM; i++) w_new_digit[i] = c_blank;
    for (int j = CAP_DIGITS; j < PAD_D; j++) w_cap_sat |= (w_cap_pad[4*j +: 4] != 4'd0);
    for (int j = IDX_DIGITS; j < PAD_D; j++) w_idx_sat |= (w_idx_pad[4*j +: 4] != 4'd0);
    for (int i = CAP_DIGITS - 1; i >= 0; i--) begin
      w_d = w_cap_sat ? 4'd9 : w_cap_pad[4*i +: 4];
      if (w_lead && (w_d == 4'd0) && (i != 0)) begin
        w_new_digit[CAP_DIGITS-1-i] = c_blank;
      end else begin
        w_new_digit[CAP_DIGITS-1-i] = w_d;
        w_lead = 1'b0;
      end
    end
    w_lead = 1'b1;
    for (int i = IDX_DIGITS - 1; i >= 0; i--) begin
      w_d = w_idx_sat ? 4'd9 : w_idx_pad[4*i +: 4];
      if (w_cap_zero) begin
        w_new_digit[NUM-1-i] = c_dash;
      end else if (w_lead && (w_d == 4'd0) && (i != 0)) begin
        w_new_digit[NUM-1-i] = c_blank;
      end else begin
        w_new_digit[NUM-1-i] = w_d;
        w_lead = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_500Hz or negedge reset) begin
    if (!reset) begin
      r_cap_bin  <= '0;
      r_idx_bin  <= '0;
      r_cap_bcd  <= '0;
      r_idx_bcd  <= '0;
      r_step     <= '0;
      r_busy     <= 1'b0;
      r_pend     <= 1'b0;
      r_pend_cap <= '0;
      r_pend_idx <= '0;
      r_cap_zero <= 1'b0;
      for (int i = 0; i < NUM; i++) r_digit[i] <= c_blank;
    end else if (!r_busy || w_final) begin
      if (w_final) begin
        r_digit    <= w_new_digit;
        r_cap_zero <= w_cap_zero;
      end
      // A queued or simultaneous load restarts the engine without an idle cycle
      if (load || r_pend) begin
        r_cap_bin <= WMAX'(w_src_cap);
        r_idx_bin <= WMAX'(w_src_idx);
        r_cap_bcd <= '0;
        r_idx_bcd <= '0;
        r_step    <= '0;
        r_busy    <= 1'b1;
      end else begin
        r_busy <= 1'b0;
      end
      r_pend <= 1'b0;
    end else begin
      r_cap_bin <= r_cap_bin << 1;
      r_idx_bin <= r_idx_bin << 1;
      r_cap_bcd <= w_cap_bcd_nx;
      r_idx_bcd <= w_idx_bcd_nx;
      r_step    <= r_step + 1'b1;
      if (load) begin
        r_pend     <= 1'b1;
        r_pend_cap <= capacity;
        r_pend_idx <= first_empty;
      end
    end
  end

`ifdef PARKING_DISPLAY_BLINK_EN
  localparam int BC_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  logic [BC_W-1:0] r_blink_cnt;
  logic            r_blink_on;

  always_ff @(posedge clk_500Hz or negedge reset) begin
    if (!reset) begin
      r_blink_cnt <= '0;
      r_blink_on  <= 1'b1;
    end else if (!r_cap_zero) begin
      r_blink_cnt <= '0;
      r_blink_on  <= 1'b1;
    end else if (r_blink_cnt == BC_W'(BLINK_HALF - 1)) begin
      r_blink_cnt <= '0;
      r_blink_on  <= ~r_blink_on;
    end else begin
      r_blink_cnt <= r_blink_cnt + 1'b1;
    end
  end
  assign w_blink_on = r_blink_on;
`else
  assign w_blink_on = 1'b1;
  // BLINK_HALF has no effect without the blink build
  if (BLINK_HALF < 1) begin : g_blink_half_unused
  end
`endif

  always_ff @(posedge clk_500Hz or negedge reset) begin
    if (!reset) begin
      r_k      <= '0;
      anodes   <= '0;
      segments <= 7'b1111111;
    end else begin
      anodes   <= w_blink_on ? (NUM'(1) << (K_W'(NUM - 1) - r_k)) : '0;
      segments <= w_blink_on ? seg_decode(r_digit[r_k]) : 7'b1111111;
      r_k      <= (r_k == K_W'(NUM - 1)) ? '0 : r_k + 1'b1;
    end
  end

endmodule
`default_nettype wire
